dlyn: RTL and testbench
=======================

DLYN -- requirements
Module: dlyn

Interface
REQ-001 Parameter NCH: default 4; number of independent delay channels, range 1..16.
REQ-002 Parameter W: default 8; delay counter width per channel, range 2..16.
REQ-003 Parameter RETRIG: default 0; 1 = an edge while busy restarts the delay, 0 = an edge while busy is ignored and flagged.
REQ-004 Port clk: input, 1 bit; the single clock, rising-edge active.
REQ-005 Port reset_n: input, 1 bit; reset, asynchronous, active-low.
REQ-006 Port in: input, NCH bits; per-channel level inputs; a trigger is a rising edge on these levels.
REQ-007 Port gate: input, NCH bits; per-channel qualifying level; an edge triggers only when gate is 1 in the detect cycle.
REQ-008 Port dly: input, NCH*W bits; per-channel delay D, channel c in bits [c*W +: W].
REQ-009 Port kill: input, NCH bits; per-channel cancel.
REQ-010 Port ovr_clr: input, 1 bit; clears all overrun flags.
REQ-011 Port p: output, NCH bits; per-channel one-cycle delayed pulse.
REQ-012 Port p_any: output, 1 bit; OR of all p bits.
REQ-013 Port busy: output, NCH bits; channel delay in progress.
REQ-014 Port ovr: output, NCH bits; sticky per-channel overrun flag.

Function
REQ-015 Each channel SHALL register in into a two-stage history s0/s1; edge = s0 & ~s1, combinational from the registers.
REQ-016 The trigger SHALL be trig = edge & gate; T denotes the cycle in which trig is 1.
REQ-017 On trig, the channel SHALL load cnt with D at the end of T; D = 0 SHALL be treated as 1.
REQ-018 dly SHALL be sampled only at the load; later changes SHALL NOT affect a running count.
REQ-019 cnt SHALL decrement once per cycle while nonzero; busy = (cnt != 0).
REQ-020 p SHALL be 1 exactly in cycle T+D (when cnt == 1 and kill = 0), for one cycle; cnt SHALL then go to 0.
REQ-021 With RETRIG = 1, trig while busy SHALL reload cnt with the current D, and the earlier pending pulse SHALL NOT fire.
REQ-022 With RETRIG = 0, trig while cnt > 1 SHALL be ignored and SHALL set ovr at the end of that cycle.
REQ-023 A trig in the cycle where cnt == 1 SHALL assert p in that cycle and SHALL load cnt with D, in both modes, with no overrun.
REQ-024 kill SHALL clear cnt at the end of the cycle and suppress p in that cycle.
REQ-025 kill SHALL take priority over a same-cycle trig: no load and no ovr.
REQ-026 ovr_clr SHALL clear all ovr bits; a same-cycle overrun on a channel SHALL win, leaving that bit set.
REQ-027 Channels SHALL be fully independent; p_any SHALL be combinational from p.

Reset
REQ-028 reset_n low SHALL immediately force:
- s0 = s1 = 1, so an input must be seen low before its first edge;
- cnt = 0, ovr = 0;
- hence p = 0, p_any = 0, busy = 0.
REQ-029 Reset during a count SHALL abandon it; no pulse SHALL issue after reset_n is released.

Structure
REQ-030 Parameter defaults and parameter range checks SHALL reside in the shared include with the other primitive constants.
REQ-031 One sub-module, dlyn_ch, SHALL implement a single channel (history, counter, overrun); dlyn SHALL instantiate it NCH times in a generate loop.

Verification
REQ-032 Reset with in[0] = 1 held high: no p. Then in[0] low 1 cycle, high, gate = 1, D = 102 -> p[0] only at T+102, busy[0] for cycles T+1..T+102.
REQ-033 Edge with gate[1] = 0 -> no busy, no p. D = 0 and D = 1 -> p at T+1. D = 255 -> p at T+255.
REQ-034 RETRIG = 0, D = 102, second edge at T+50 -> p at T+102 only, ovr = 1; ovr_clr -> ovr = 0. RETRIG = 1, same stimulus -> p at T+152 only, ovr = 0.
REQ-035 kill at T+102 -> no p, busy 0. trig + kill in the same cycle -> no load. trig at T+D -> p at T+D and again at T+2D.
REQ-036 reset_n low at T+40 -> busy 0 at once; no p through T+200 after release; ovr cleared. All four channels triggered with distinct D -> p_any pulses at each of the four times.

Source files
------------

// File: rtl/dlyn_pkg.sv
// ============================================================================
// Module : dlyn_pkg
// Brief  : Shared constants, parameter defaults and range checks for dlyn.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dlyn_pkg;

   // Parameter defaults
   localparam int C_NCH_DEF    = 4;
   localparam int C_W_DEF      = 8;
   localparam int C_RETRIG_DEF = 0;

   // Legal parameter ranges
   localparam int C_NCH_MIN = 1;
   localparam int C_NCH_MAX = 16;
   localparam int C_W_MIN   = 2;
   localparam int C_W_MAX   = 16;

   // Behaviour of a trigger that arrives while a channel is counting
   typedef enum logic [0:0] {
      RETRIG_IGNORE  = 1'b0,
      RETRIG_RESTART = 1'b1
   } retrig_e;

   function automatic bit dlyn_params_ok(input int nch, input int w, input int retrig);
      return (nch >= C_NCH_MIN) && (nch <= C_NCH_MAX) &&
             (w >= C_W_MIN) && (w <= C_W_MAX) &&
             ((retrig == 0) || (retrig == 1));
   endfunction

endpackage

`default_nettype wire

// File: rtl/dlyn_ch.sv
// ============================================================================
// Module : dlyn_ch
// Brief  : One delay channel: edge history, down-counter and overrun flag.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dlyn_ch
   import dlyn_pkg::*;
#(
   parameter int W      = C_W_DEF,
   parameter int RETRIG = C_RETRIG_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in,
   input  logic         gate,
   input  logic [W-1:0] dly,
   input  logic         kill,
   input  logic         ovr_clr,
   output logic         p,
   output logic         busy,
   output logic         ovr
);

   localparam retrig_e c_mode = (RETRIG != 0) ? RETRIG_RESTART : RETRIG_IGNORE;

   logic         r_s0;
   logic         r_s1;
   logic [W-1:0] r_cnt;
   logic         r_ovr;

   logic         w_trig;
   logic         w_idle_or_last;
   logic         w_load;
   logic         w_ovr_set;
   logic [W-1:0] w_deff;
   logic [W-1:0] w_cnt_nxt;

   assign w_trig         = r_s0 & ~r_s1 & gate;
   // cnt <= 1: either idle or in the firing cycle, where a new load is always legal
   assign w_idle_or_last = (r_cnt[W-1:1] == '0);
   assign w_deff         = (dly == '0) ? W'(1) : dly;

   assign w_load    = ~kill & w_trig & ((c_mode == RETRIG_RESTART) | w_idle_or_last);
   assign w_ovr_set = ~kill & w_trig & ~w_load;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (kill) begin
         w_cnt_nxt = '0;
      end else if (w_load) begin
         w_cnt_nxt = w_deff;
      end else if (r_cnt != '0) begin
         w_cnt_nxt = r_cnt - W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s0  <= 1'b1;
         r_s1  <= 1'b1;
         r_cnt <= '0;
         r_ovr <= 1'b0;
      end else begin
         r_s0  <= in;
         r_s1  <= r_s0;
         r_cnt <= w_cnt_nxt;
         r_ovr <= w_ovr_set | (r_ovr & ~ovr_clr);
      end
   end

   assign p    = (r_cnt == W'(1)) & ~kill;
   assign busy = (r_cnt != '0);
   assign ovr  = r_ovr;

endmodule

`default_nettype wire

// File: rtl/dlyn.sv
// ============================================================================
// Module : dlyn
// Brief  : NCH independent edge-triggered, gated, programmable pulse delays.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dlyn
   import dlyn_pkg::*;
#(
   parameter int NCH    = C_NCH_DEF,
   parameter int W      = C_W_DEF,
   parameter int RETRIG = C_RETRIG_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NCH-1:0]   in,
   input  logic [NCH-1:0]   gate,
   input  logic [NCH*W-1:0] dly,
   input  logic [NCH-1:0]   kill,
   input  logic             ovr_clr,
   output logic [NCH-1:0]   p,
   output logic             p_any,
   output logic [NCH-1:0]   busy,
   output logic [NCH-1:0]   ovr
);

   if (!dlyn_params_ok(NCH, W, RETRIG)) begin : g_bad_param
      $error("dlyn: NCH, W or RETRIG outside the supported range");
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      dlyn_ch #(
         .W      (W),
         .RETRIG (RETRIG)
      ) u_ch (
         .clk     (clk),
         .reset_n (reset_n),
         .in      (in[c]),
         .gate    (gate[c]),
         .dly     (dly[c*W +: W]),
         .kill    (kill[c]),
         .ovr_clr (ovr_clr),
         .p       (p[c]),
         .busy    (busy[c]),
         .ovr     (ovr[c])
      );
   end

   assign p_any = |p;

endmodule

`default_nettype wire

// File: tb/tb_dlyn.sv
// ============================================================================
// Module : tb_dlyn
// Brief  : Scoreboard bench for dlyn, both RETRIG modes side by side.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dlyn;

   localparam int NCH = 4;
   localparam int W   = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic [3:0]  in_d, gate_d, kill_d;
   logic [31:0] dly_d;
   logic        clr_d;

   logic [3:0]  p0, b0, o0, p1, b1, o1;
   logic        pa0, pa1;

   dlyn #(.NCH(NCH), .W(W), .RETRIG(0)) u_dut0 (
      .clk(clk), .reset_n(reset_n), .in(in_d), .gate(gate_d), .dly(dly_d),
      .kill(kill_d), .ovr_clr(clr_d), .p(p0), .p_any(pa0), .busy(b0), .ovr(o0)
   );

   dlyn #(.NCH(NCH), .W(W), .RETRIG(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .in(in_d), .gate(gate_d), .dly(dly_d),
      .kill(kill_d), .ovr_clr(clr_d), .p(p1), .p_any(pa1), .busy(b1), .ovr(o1)
   );

   typedef struct packed {
      logic [3:0] p;
      logic [3:0] busy;
      logic [3:0] ovr;
      logic       pany;
   } st_t;

   typedef struct packed {
      int         cyc;
      logic [3:0] p;
   } pl_t;

   st_t sq0[$], sq1[$];
   pl_t pq0[$], pq1[$];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Next-cycle stimulus values
   logic [3:0]  v_in, v_gate, v_kill;
   logic [31:0] v_dly;
   logic        v_clr, v_rst;

   // Reference model: a pending pulse is an absolute deadline cycle (-1 = none)
   logic [3:0] m_s0, m_s1;
   int         m_dl [2][4];
   logic [3:0] m_ovr [2];

   task automatic model_reset();
      m_s0 = '1;
      m_s1 = '1;
      for (int m = 0; m < 2; m++) begin
         m_ovr[m] = '0;
         for (int c = 0; c < 4; c++) m_dl[m][c] = -1;
      end
   endtask

   task automatic model_clock();
      int  d;
      bit  trig, fire_now, set_ovr;
      if (!reset_n) begin
         model_reset();
         return;
      end
      for (int m = 0; m < 2; m++) begin
         for (int c = 0; c < 4; c++) begin
            d        = int'(dly_d[c*8 +: 8]);
            if (d == 0) d = 1;
            trig     = m_s0[c] && !m_s1[c] && gate_d[c];
            fire_now = (m_dl[m][c] == cyc);
            set_ovr  = 1'b0;
            if (kill_d[c]) begin
               m_dl[m][c] = -1;
            end else if (trig && (m == 1 || m_dl[m][c] < 0 || fire_now)) begin
               m_dl[m][c] = cyc + d;
            end else begin
               if (trig) set_ovr = 1'b1;
               if (fire_now) m_dl[m][c] = -1;
            end
            if (set_ovr) m_ovr[m][c] = 1'b1;
            else if (clr_d) m_ovr[m][c] = 1'b0;
         end
      end
      m_s1 = m_s0;
      m_s0 = in_d;
   endtask

   task automatic push_expect();
      st_t e;
      pl_t x;
      for (int m = 0; m < 2; m++) begin
         e.ovr = m_ovr[m];
         for (int c = 0; c < 4; c++) begin
            e.busy[c] = (m_dl[m][c] >= cyc);
            e.p[c]    = (m_dl[m][c] == cyc) && !kill_d[c];
         end
         e.pany = |e.p;
         x.cyc  = cyc;
         x.p    = e.p;
         if (m == 0) begin
            sq0.push_back(e);
            if (e.p != 0) pq0.push_back(x);
         end else begin
            sq1.push_back(e);
            if (e.p != 0) pq1.push_back(x);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_clock();
      in_d    = v_in;
      gate_d  = v_gate;
      kill_d  = v_kill;
      dly_d   = v_dly;
      clr_d   = v_clr;
      reset_n = v_rst;
      if (!reset_n) model_reset();
      cyc++;
      push_expect();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   // Low for one cycle then high; the cycle after this task returns is T
   task automatic edge_ch(input logic [3:0] mask);
      v_in = v_in & ~mask;
      step();
      v_in = v_in | mask;
      step();
   endtask

   task automatic chk_st(input int m, input st_t e, input st_t a);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL status%0d cyc=%0d got p=%b busy=%b ovr=%b any=%b want p=%b busy=%b ovr=%b any=%b",
                  m, cyc, a.p, a.busy, a.ovr, a.pany, e.p, e.busy, e.ovr, e.pany);
      end
   endtask

   task automatic chk_pulse(input int m, input logic [3:0] a, input bit have, input pl_t x);
      n_chk++;
      if (!have) begin
         n_fail++;
         $display("FAIL pulse%0d cyc=%0d got p=%b want no pulse", m, cyc, a);
      end else if (x.cyc != cyc || x.p !== a) begin
         n_fail++;
         $display("FAIL pulse%0d got cyc=%0d p=%b want cyc=%0d p=%b", m, cyc, a, x.cyc, x.p);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      st_t e;
      pl_t x;
      bit  have;
      if (sq0.size() > 0) begin
         e = sq0.pop_front();
         chk_st(0, e, {p0, b0, o0, pa0});
      end
      if (sq1.size() > 0) begin
         e = sq1.pop_front();
         chk_st(1, e, {p1, b1, o1, pa1});
      end
      if (p0 != 0) begin
         have = (pq0.size() > 0);
         x    = have ? pq0.pop_front() : '0;
         chk_pulse(0, p0, have, x);
      end
      if (p1 != 0) begin
         have = (pq1.size() > 0);
         x    = have ? pq1.pop_front() : '0;
         chk_pulse(1, p1, have, x);
      end
   end

   initial begin
      int sel;
      v_in = '1; v_gate = '1; v_kill = '0; v_clr = 1'b0; v_rst = 1'b0;
      v_dly = {8'd0, 8'd0, 8'd0, 8'd102};
      in_d = v_in; gate_d = v_gate; kill_d = v_kill; dly_d = v_dly;
      clr_d = v_clr; reset_n = 1'b0;
      model_reset();

      // Reset with inputs high, then a first gated edge, D = 102
      run(3);
      v_rst = 1'b1;
      run(5);
      edge_ch(4'b0001);
      run(110);

      // Gate low blocks the edge; D = 0, 1 and 255
      v_gate = 4'b1101;
      edge_ch(4'b0010);
      run(5);
      v_gate = '1;
      v_dly[15:8] = 8'd0;
      edge_ch(4'b0010);
      run(3);
      v_dly[23:16] = 8'd1;
      edge_ch(4'b0100);
      run(3);
      v_dly[31:24] = 8'd255;
      edge_ch(4'b1000);
      run(258);

      // Second edge at T+50, then ovr_clr
      edge_ch(4'b0001);
      run(48);
      edge_ch(4'b0001);
      run(160);
      v_clr = 1'b1;
      run(1);
      v_clr = 1'b0;
      run(3);

      // kill in the firing cycle
      edge_ch(4'b0001);
      run(102);
      v_kill = 4'b0001;
      run(1);
      v_kill = '0;
      run(3);

      // kill together with the trigger
      edge_ch(4'b0001);
      v_kill = 4'b0001;
      run(1);
      v_kill = '0;
      run(110);

      // Trigger exactly in the firing cycle, D = 10
      v_dly[7:0] = 8'd10;
      edge_ch(4'b0001);
      run(8);
      edge_ch(4'b0001);
      run(25);

      // Overrun, then reset at T+40 during the count
      v_dly[7:0] = 8'd102;
      edge_ch(4'b0001);
      run(20);
      edge_ch(4'b0001);
      run(18);
      v_rst = 1'b0;
      run(3);
      v_rst = 1'b1;
      run(200);

      // All channels, distinct delays
      v_dly = {8'd17, 8'd13, 8'd9, 8'd5};
      edge_ch(4'hF);
      run(25);

      // Randomised traffic
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < 4; c++) begin
            if ($urandom_range(0, 5) == 0) v_in[c] = ~v_in[c];
            v_gate[c] = ($urandom_range(0, 7) != 0);
            v_kill[c] = ($urandom_range(0, 60) == 0);
         end
         v_clr = ($urandom_range(0, 40) == 0);
         if ($urandom_range(0, 15) == 0) begin
            sel = int'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
               0:       v_dly[sel*8 +: 8] = 8'd0;
               1:       v_dly[sel*8 +: 8] = 8'd1;
               9:       v_dly[sel*8 +: 8] = 8'($urandom_range(100, 255));
               default: v_dly[sel*8 +: 8] = 8'($urandom_range(2, 25));
            endcase
         end
         v_rst = !(i >= 1500 && i < 1502);
         step();
      end
      v_kill = '0;
      v_clr  = 1'b0;
      run(2);
      @(negedge clk);
      #1;

      // Every predicted pulse must have been seen
      n_chk++;
      if (pq0.size() != 0) begin
         n_fail++;
         $display("FAIL leftover0 got %0d unseen pulses want 0", pq0.size());
      end
      n_chk++;
      if (pq1.size() != 0) begin
         n_fail++;
         $display("FAIL leftover1 got %0d unseen pulses want 0", pq1.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
